// File: rtl/cpu_types_pkg.sv
// Shared pipeline types for the 5-stage MIPS core.
//   word_t     : datapath / address word
//   regbits_t  : register-select field
//   memstate_t : data-memory access FSM states
package cpu_types_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } memstate_t;

endpackage

// File: rtl/ex_mem_if.sv
// Signal bundle for the EX/MEM stage.
//   modport exmem : view of the stage itself
//   mem           : view of the data memory
//   tb            : view of a driver that owns every stage input
// With EX_MEM_STALL_CNT_EN defined the bundle also carries stall_cnt and
// mem_ops.
interface ex_mem_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              CLK;
    logic              RST;
    logic              en;
    logic              flush;
    logic [DATA_W-1:0] alu_i;
    logic [DATA_W-1:0] rdat2_i;
    logic [DATA_W-1:0] pc4_i;
    logic [REG_W-1:0]  wsel_i;
    logic              RegWr_i;
    logic              dREN_i;
    logic              dWEN_i;
    logic              MemToReg_i;
    logic              halt_i;
    logic              dhit;
    logic [DATA_W-1:0] dmemload;
    logic              dmemREN;
    logic              dmemWEN;
    logic [DATA_W-1:0] dmemaddr;
    logic [DATA_W-1:0] dmemstore;
    logic              mem_stall;
    logic [DATA_W-1:0] alu_o;
    logic [DATA_W-1:0] pc4_o;
    logic [DATA_W-1:0] load_o;
    logic [REG_W-1:0]  wsel_o;
    logic              RegWr_o;
    logic              MemToReg_o;
    logic              halt_o;
    logic              valid_o;
`ifdef EX_MEM_STALL_CNT_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       mem_ops;
`endif

    modport exmem (
        input  CLK, RST, en, flush, alu_i, rdat2_i, pc4_i, wsel_i,
               RegWr_i, dREN_i, dWEN_i, MemToReg_i, halt_i, dhit, dmemload,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
               alu_o, pc4_o, load_o, wsel_o, RegWr_o, MemToReg_o, halt_o,
`ifdef EX_MEM_STALL_CNT_EN
               stall_cnt, mem_ops,
`endif
               valid_o
    );

    modport mem (
        input  CLK, dmemREN, dmemWEN, dmemaddr, dmemstore,
        output dhit, dmemload
    );

    modport tb (
        output CLK, RST, en, flush, alu_i, rdat2_i, pc4_i, wsel_i,
               RegWr_i, dREN_i, dWEN_i, MemToReg_i, halt_i, dhit, dmemload,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
               alu_o, pc4_o, load_o, wsel_o, RegWr_o, MemToReg_o, halt_o,
`ifdef EX_MEM_STALL_CNT_EN
               stall_cnt, mem_ops,
`endif
               valid_o
    );

endinterface

// File: rtl/dmem_req_fsm.sv
// Data-memory request controller for the EX/MEM stage.
//
// state | meaning
// ------+------------------------------------------
// IDLE  | no access outstanding, request lines low
// WAIT  | access outstanding, request held until dhit
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   start_i             a memory instruction is being captured this cycle
//   dren_i, dwen_i      latched read/write controls of the captured instr
//   addr_i, store_i     latched address / store data
//   dhit_i              memory completes the access
//   dmemREN_o/WEN_o     request strobes
//   dmemaddr_o          request address (always the latched ALU result)
//   dmemstore_o         store data (zero outside WAIT)
//   mem_stall_o         freeze upstream stages
//   busy_o              FSM is in WAIT
//   done_o              access completes this cycle (dhit while in WAIT)
module dmem_req_fsm
    import cpu_types_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start_i,
    input  logic              dren_i,
    input  logic              dwen_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] store_i,
    input  logic              dhit_i,
    output logic              dmemREN_o,
    output logic              dmemWEN_o,
    output logic [DATA_W-1:0] dmemaddr_o,
    output logic [DATA_W-1:0] dmemstore_o,
    output logic              mem_stall_o,
    output logic              busy_o,
    output logic              done_o
);

    memstate_t state_q, state_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dmemREN_o   = 1'b0;
        dmemWEN_o   = 1'b0;
        dmemaddr_o  = addr_i;
        dmemstore_o = '0;
        mem_stall_o = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                dmemREN_o   = dren_i;
                dmemWEN_o   = dwen_i;
                dmemstore_o = store_i;
                // Combinational so a zero-wait hit never stalls upstream.
                mem_stall_o = ~dhit_i;
                if (dhit_i) begin
                    done_o  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q == WAIT);

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register fused with the data-memory access controller.
// Latches EX results, issues one dmem access per memory instruction, holds
// the request until dhit and stalls upstream while the access is pending.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   en, flush                advance enable / bubble insert from hazard unit
//   alu_i .. halt_i          EX results and controls from ID/EX
//   dhit, dmemload           data memory response
//   dmemREN .. dmemstore     data memory request
//   mem_stall                freeze IF/ID/EX
//   alu_o .. valid_o         towards MEM/WB
//
// Optional: defining EX_MEM_STALL_CNT_EN adds stall_cnt (saturating count of
// stalled cycles) and mem_ops (saturating count of completed accesses).
module ex_mem_stage
    import cpu_types_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              en,
    input  logic              flush,
    input  logic [DATA_W-1:0] alu_i,
    input  logic [DATA_W-1:0] rdat2_i,
    input  logic [DATA_W-1:0] pc4_i,
    input  logic [REG_W-1:0]  wsel_i,
    input  logic              RegWr_i,
    input  logic              dREN_i,
    input  logic              dWEN_i,
    input  logic              MemToReg_i,
    input  logic              halt_i,
    input  logic              dhit,
    input  logic [DATA_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [DATA_W-1:0] dmemaddr,
    output logic [DATA_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic [DATA_W-1:0] alu_o,
    output logic [DATA_W-1:0] pc4_o,
    output logic [DATA_W-1:0] load_o,
    output logic [REG_W-1:0]  wsel_o,
    output logic              RegWr_o,
    output logic              MemToReg_o,
    output logic              halt_o,
`ifdef EX_MEM_STALL_CNT_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       mem_ops,
`endif
    output logic              valid_o
);

    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] rdat2_q, rdat2_d;
    logic [DATA_W-1:0] pc4_q, pc4_d;
    logic [DATA_W-1:0] load_q, load_d;
    logic [REG_W-1:0]  wsel_q, wsel_d;
    logic              regwr_q, regwr_d;
    logic              dren_q, dren_d;
    logic              dwen_q, dwen_d;
    logic              memtoreg_q, memtoreg_d;
    logic              halt_q, halt_d;
    logic              valid_q, valid_d;

    logic busy;
    logic done;
    logic capture;
    logic start;

    // Nothing is captured while an access is outstanding, not even on the
    // dhit cycle; the next instruction lands in the following IDLE cycle.
    assign capture = ~busy & en & ~flush;
    assign start   = capture & (dREN_i | dWEN_i);

    always_comb begin
        alu_d      = alu_q;
        rdat2_d    = rdat2_q;
        pc4_d      = pc4_q;
        load_d     = load_q;
        wsel_d     = wsel_q;
        regwr_d    = regwr_q;
        dren_d     = dren_q;
        dwen_d     = dwen_q;
        memtoreg_d = memtoreg_q;
        halt_d     = halt_q;
        valid_d    = valid_q;
        if (busy) begin
            if (done && dren_q) begin
                load_d = dmemload;
            end
        end else if (flush) begin
            // Bubble: everything clears except the sticky halt.
            alu_d      = '0;
            rdat2_d    = '0;
            pc4_d      = '0;
            load_d     = '0;
            wsel_d     = '0;
            regwr_d    = 1'b0;
            dren_d     = 1'b0;
            dwen_d     = 1'b0;
            memtoreg_d = 1'b0;
            valid_d    = 1'b0;
        end else if (en) begin
            alu_d      = alu_i;
            rdat2_d    = rdat2_i;
            pc4_d      = pc4_i;
            load_d     = '0;
            wsel_d     = wsel_i;
            regwr_d    = RegWr_i;
            dren_d     = dREN_i;
            // Read and write together is illegal; the read takes precedence.
            dwen_d     = dWEN_i & ~dREN_i;
            memtoreg_d = MemToReg_i;
            halt_d     = halt_q | halt_i;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            alu_q      <= '0;
            rdat2_q    <= '0;
            pc4_q      <= '0;
            load_q     <= '0;
            wsel_q     <= '0;
            regwr_q    <= 1'b0;
            dren_q     <= 1'b0;
            dwen_q     <= 1'b0;
            memtoreg_q <= 1'b0;
            halt_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            alu_q      <= alu_d;
            rdat2_q    <= rdat2_d;
            pc4_q      <= pc4_d;
            load_q     <= load_d;
            wsel_q     <= wsel_d;
            regwr_q    <= regwr_d;
            dren_q     <= dren_d;
            dwen_q     <= dwen_d;
            memtoreg_q <= memtoreg_d;
            halt_q     <= halt_d;
            valid_q    <= valid_d;
        end
    end

    dmem_req_fsm #(
        .DATA_W (DATA_W)
    ) u_req_fsm (
        .CLK         (CLK),
        .RST         (RST),
        .start_i     (start),
        .dren_i      (dren_q),
        .dwen_i      (dwen_q),
        .addr_i      (alu_q),
        .store_i     (rdat2_q),
        .dhit_i      (dhit),
        .dmemREN_o   (dmemREN),
        .dmemWEN_o   (dmemWEN),
        .dmemaddr_o  (dmemaddr),
        .dmemstore_o (dmemstore),
        .mem_stall_o (mem_stall),
        .busy_o      (busy),
        .done_o      (done)
    );

    assign alu_o      = alu_q;
    assign pc4_o      = pc4_q;
    assign load_o     = load_q;
    assign wsel_o     = wsel_q;
    assign RegWr_o    = regwr_q;
    assign MemToReg_o = memtoreg_q;
    assign halt_o     = halt_q;
    assign valid_o    = valid_q;

`ifdef EX_MEM_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] mem_ops_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= '0;
            mem_ops_q   <= '0;
        end else begin
            if (mem_stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (done && (mem_ops_q != '1)) begin
                mem_ops_q <= mem_ops_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign mem_ops   = mem_ops_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
`timescale 1ns/1ps
module tb_ex_mem_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    ex_mem_if #(.DATA_W(DW), .REG_W(RW)) b ();

    ex_mem_stage #(.DATA_W(DW), .REG_W(RW)) dut (
        .CLK        (b.CLK),
        .RST        (b.RST),
        .en         (b.en),
        .flush      (b.flush),
        .alu_i      (b.alu_i),
        .rdat2_i    (b.rdat2_i),
        .pc4_i      (b.pc4_i),
        .wsel_i     (b.wsel_i),
        .RegWr_i    (b.RegWr_i),
        .dREN_i     (b.dREN_i),
        .dWEN_i     (b.dWEN_i),
        .MemToReg_i (b.MemToReg_i),
        .halt_i     (b.halt_i),
        .dhit       (b.dhit),
        .dmemload   (b.dmemload),
        .dmemREN    (b.dmemREN),
        .dmemWEN    (b.dmemWEN),
        .dmemaddr   (b.dmemaddr),
        .dmemstore  (b.dmemstore),
        .mem_stall  (b.mem_stall),
        .alu_o      (b.alu_o),
        .pc4_o      (b.pc4_o),
        .load_o     (b.load_o),
        .wsel_o     (b.wsel_o),
        .RegWr_o    (b.RegWr_o),
        .MemToReg_o (b.MemToReg_o),
        .halt_o     (b.halt_o),
`ifdef EX_MEM_STALL_CNT_EN
        .stall_cnt  (b.stall_cnt),
        .mem_ops    (b.mem_ops),
`endif
        .valid_o    (b.valid_o)
    );

    initial b.CLK = 1'b0;
    always #5 b.CLK = ~b.CLK;

    int tests_run    = 0;
    int tests_failed = 0;

    // Architectural expectation of what the stage presents downstream.
    logic [31:0] e_alu, e_pc4, e_load, e_store;
    logic [4:0]  e_wsel;
    logic        e_regwr, e_m2r, e_halt, e_valid, e_dren, e_dwen;

    // Upstream protocol rules the stage relies on.
    always @(negedge b.CLK) begin
        if (!b.RST) begin
            assert (!(b.dREN_i && b.dWEN_i))
                else $error("FAIL proto_ren_wen: both dREN_i and dWEN_i high");
            assert (!(b.flush && b.mem_stall))
                else $error("FAIL proto_flush_stall: flush while mem_stall");
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge b.CLK);
        #2;
    endtask

    task automatic m_reset();
        e_alu = '0; e_pc4 = '0; e_load = '0; e_store = '0; e_wsel = '0;
        e_regwr = 0; e_m2r = 0; e_halt = 0; e_valid = 0; e_dren = 0; e_dwen = 0;
    endtask

    task automatic m_capture();
        e_alu   = b.alu_i;
        e_store = b.rdat2_i;
        e_pc4   = b.pc4_i;
        e_wsel  = b.wsel_i;
        e_regwr = b.RegWr_i;
        e_m2r   = b.MemToReg_i;
        e_dren  = b.dREN_i;
        e_dwen  = b.dWEN_i && !b.dREN_i;
        e_halt  = e_halt || b.halt_i;
        e_valid = 1'b1;
        e_load  = '0;
    endtask

    task automatic m_flush();
        e_alu = '0; e_pc4 = '0; e_load = '0; e_store = '0; e_wsel = '0;
        e_regwr = 0; e_m2r = 0; e_valid = 0; e_dren = 0; e_dwen = 0;
    endtask

    function automatic logic [104:0] exp_vec();
        return {e_alu, e_pc4, e_load, e_wsel, e_regwr, e_m2r, e_halt, e_valid};
    endfunction

    function automatic logic [104:0] act_vec();
        return {b.alu_o, b.pc4_o, b.load_o, b.wsel_o, b.RegWr_o, b.MemToReg_o,
                b.halt_o, b.valid_o};
    endfunction

    task automatic rand_inputs(input logic en_v);
        int kind;
        kind         = $urandom_range(0, 2);
        b.en         = en_v;
        b.flush      = 1'b0;
        b.alu_i      = $urandom;
        b.rdat2_i    = $urandom;
        b.pc4_i      = $urandom;
        b.wsel_i     = 5'($urandom);
        b.RegWr_i    = 1'($urandom);
        b.MemToReg_i = 1'($urandom);
        b.dREN_i     = (kind == 1);
        b.dWEN_i     = (kind == 2);
        b.halt_i     = 1'b0;
        b.dhit       = 1'b0;
        b.dmemload   = $urandom;
    endtask

    task automatic drive_instr(input logic [31:0] alu, input logic [31:0] rd2,
                               input logic [4:0] ws, input logic rw,
                               input logic ren, input logic wen,
                               input logic m2r, input logic hlt);
        rand_inputs(1'b1);
        b.alu_i = alu; b.rdat2_i = rd2; b.wsel_i = ws; b.RegWr_i = rw;
        b.dREN_i = ren; b.dWEN_i = wen; b.MemToReg_i = m2r; b.halt_i = hlt;
    endtask

    task automatic test_reset();
        b.RST = 1'b1;
        rand_inputs(1'b1);
        tick();
        rand_inputs(1'b1);
        tick();
        b.RST = 1'b0;
        m_reset();
        tests_run++;
        if (act_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL reset_regs: got %h expected %h", act_vec(), exp_vec());
        end
        tests_run++;
        if ({b.dmemREN, b.dmemWEN, b.mem_stall, b.dmemaddr, b.dmemstore} !== 67'd0) begin
            tests_failed++;
            $display("FAIL reset_req: got ren=%b wen=%b stall=%b addr=%h store=%h expected all 0",
                     b.dmemREN, b.dmemWEN, b.mem_stall, b.dmemaddr, b.dmemstore);
        end
        rand_inputs(1'b0);
    endtask

    task automatic test_nonmem();
        drive_instr(32'h0000_0010, $urandom, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        m_capture();
        tick();
        rand_inputs(1'b0);
        #1;
        tests_run++;
        if (act_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL nonmem_regs: got %h expected %h", act_vec(), exp_vec());
        end
        tests_run++;
        if ({b.dmemREN, b.dmemWEN, b.mem_stall, b.dmemaddr} !== {3'b000, 32'h10}) begin
            tests_failed++;
            $display("FAIL nonmem_req: got ren=%b wen=%b stall=%b addr=%h expected 0 0 0 00000010",
                     b.dmemREN, b.dmemWEN, b.mem_stall, b.dmemaddr);
        end
    endtask

    task automatic test_load_latency();
        int stalls = 0;
        drive_instr(32'h0000_0100, $urandom, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        m_capture();
        tick();
        for (int k = 1; k <= 3; k++) begin
            rand_inputs(1'($urandom));
            b.dhit     = (k == 3);
            b.dmemload = (k == 3) ? 32'hDEAD_BEEF : $urandom;
            #1;
            if (b.mem_stall === 1'b1) stalls++;
            tests_run++;
            if ({b.dmemREN, b.dmemWEN, b.dmemaddr, b.mem_stall} !== {2'b10, 32'h100, (k != 3)}) begin
                tests_failed++;
                $display("FAIL load_req cyc%0d: got ren=%b wen=%b addr=%h stall=%b expected 1 0 00000100 %b",
                         k, b.dmemREN, b.dmemWEN, b.dmemaddr, b.mem_stall, (k != 3));
            end
            tick();
        end
        rand_inputs(1'b0);
        e_load = 32'hDEAD_BEEF;
        #1;
        tests_run++;
        if (stalls != 2) begin
            tests_failed++;
            $display("FAIL load_stall_cycles: got %0d expected 2", stalls);
        end
        tests_run++;
        if ({act_vec(), b.dmemREN} !== {exp_vec(), 1'b0}) begin
            tests_failed++;
            $display("FAIL load_done: got %h ren=%b expected %h ren=0", act_vec(), b.dmemREN, exp_vec());
        end
    endtask

    task automatic test_store_zero_wait();
        drive_instr(32'h0000_0200, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        m_capture();
        tick();
        rand_inputs(1'b1);
        b.dhit = 1'b1;
        #1;
        tests_run++;
        if ({b.dmemREN, b.dmemWEN, b.mem_stall, b.dmemaddr, b.dmemstore}
            !== {3'b010, 32'h200, 32'h1234_5678}) begin
            tests_failed++;
            $display("FAIL store_req: got ren=%b wen=%b stall=%b addr=%h store=%h expected 0 1 0 00000200 12345678",
                     b.dmemREN, b.dmemWEN, b.mem_stall, b.dmemaddr, b.dmemstore);
        end
        tick();
        rand_inputs(1'b0);
        #1;
        tests_run++;
        if ({act_vec(), b.dmemWEN, b.mem_stall, b.dmemstore} !== {exp_vec(), 2'b00, 32'h0}) begin
            tests_failed++;
            $display("FAIL store_done: got %h wen=%b stall=%b store=%h expected %h 0 0 0",
                     act_vec(), b.dmemWEN, b.mem_stall, b.dmemstore, exp_vec());
        end
    endtask

    task automatic test_flush_hold();
        drive_instr($urandom, $urandom, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        m_capture();
        tick();
        rand_inputs(1'($urandom));
        b.flush = 1'b1;
        m_flush();
        tick();
        tests_run++;
        if (act_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL flush_bubble: got %h expected %h", act_vec(), exp_vec());
        end
        drive_instr($urandom, $urandom, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        m_capture();
        tick();
        for (int k = 0; k < 3; k++) begin
            rand_inputs(1'b0);
            tick();
            tests_run++;
            if (act_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL hold_cyc%0d: got %h expected %h", k, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_flush_in_wait();
        logic [31:0] ld;
        drive_instr(32'h0000_0300, $urandom, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        m_capture();
        tick();
        rand_inputs(1'b1);
        tick();
        // flush lands on the dhit cycle, where mem_stall is already low
        rand_inputs(1'b1);
        b.flush = 1'b1;
        b.dhit  = 1'b1;
        ld      = $urandom;
        b.dmemload = ld;
        e_load  = ld;
        tick();
        rand_inputs(1'b0);
        tests_run++;
        if (act_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL flush_in_wait: got %h expected %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid_wait();
        drive_instr(32'h0000_0400, $urandom, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        m_capture();
        tick();
        rand_inputs(1'b0);
        tick();
        b.RST      = 1'b1;
        b.dhit     = 1'b1;
        b.dmemload = 32'hCAFE_F00D;
        tick();
        b.RST = 1'b0;
        rand_inputs(1'b0);
        m_reset();
        #1;
        tests_run++;
        if ({act_vec(), b.dmemREN, b.mem_stall} !== {exp_vec(), 2'b00}) begin
            tests_failed++;
            $display("FAIL reset_mid_wait: got %h ren=%b stall=%b expected %h 0 0",
                     act_vec(), b.dmemREN, b.mem_stall, exp_vec());
        end
    endtask

    task automatic test_halt_sticky();
        drive_instr($urandom, $urandom, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        m_capture();
        tick();
        drive_instr($urandom, $urandom, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        m_capture();
        tick();
        tests_run++;
        if ({act_vec(), b.halt_o} !== {exp_vec(), 1'b1}) begin
            tests_failed++;
            $display("FAIL halt_after_capture: got %h halt=%b expected %h halt=1",
                     act_vec(), b.halt_o, exp_vec());
        end
        rand_inputs(1'b0);
        b.flush = 1'b1;
        m_flush();
        tick();
        rand_inputs(1'b0);
        tests_run++;
        if ({act_vec(), b.halt_o} !== {exp_vec(), 1'b1}) begin
            tests_failed++;
            $display("FAIL halt_after_flush: got %h halt=%b expected %h halt=1",
                     act_vec(), b.halt_o, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            int pre;
            pre = $urandom_range(0, 3);
            if (pre == 1) begin
                rand_inputs(1'b0);
                tick();
                tests_run++;
                if (act_vec() !== exp_vec()) begin
                    tests_failed++;
                    $display("FAIL rnd_hold[%0d]: got %h expected %h", n, act_vec(), exp_vec());
                end
            end else if (pre == 2) begin
                rand_inputs(1'($urandom));
                b.flush = 1'b1;
                m_flush();
                tick();
                tests_run++;
                if (act_vec() !== exp_vec()) begin
                    tests_failed++;
                    $display("FAIL rnd_flush[%0d]: got %h expected %h", n, act_vec(), exp_vec());
                end
            end
            rand_inputs(1'b1);
            b.halt_i = ($urandom_range(0, 31) == 0);
            m_capture();
            tick();
            tests_run++;
            if (act_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL rnd_capture[%0d]: got %h expected %h", n, act_vec(), exp_vec());
            end
            if (e_dren || e_dwen) begin
                int lat;
                logic [31:0] ld;
                lat = $urandom_range(1, 4);
                ld  = e_load;
                for (int k = 1; k <= lat; k++) begin
                    rand_inputs(1'($urandom));
                    b.dhit  = (k == lat);
                    b.flush = (k == lat) ? 1'($urandom) : 1'b0;
                    if (k == lat && e_dren) ld = b.dmemload;
                    #1;
                    tests_run++;
                    if ({b.dmemREN, b.dmemWEN, b.dmemaddr, b.dmemstore, b.mem_stall}
                        !== {e_dren, e_dwen, e_alu, e_store, (k != lat)}) begin
                        tests_failed++;
                        $display("FAIL rnd_req[%0d.%0d]: got ren=%b wen=%b addr=%h store=%h stall=%b expected %b %b %h %h %b",
                                 n, k, b.dmemREN, b.dmemWEN, b.dmemaddr, b.dmemstore, b.mem_stall,
                                 e_dren, e_dwen, e_alu, e_store, (k != lat));
                    end
                    tick();
                end
                e_load = ld;
                tests_run++;
                if (act_vec() !== exp_vec()) begin
                    tests_failed++;
                    $display("FAIL rnd_done[%0d]: got %h expected %h", n, act_vec(), exp_vec());
                end
            end
        end
        rand_inputs(1'b0);
    endtask

`ifdef EX_MEM_STALL_CNT_EN
    task automatic test_counters();
        b.RST = 1'b1;
        rand_inputs(1'b0);
        tick();
        b.RST = 1'b0;
        m_reset();
        drive_instr($urandom, $urandom, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        for (int k = 1; k <= 4; k++) begin
            rand_inputs(1'b0);
            b.dhit = (k == 4);
            tick();
        end
        drive_instr($urandom, $urandom, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        rand_inputs(1'b0);
        b.dhit = 1'b1;
        tick();
        rand_inputs(1'b0);
        tests_run++;
        if ({b.stall_cnt, b.mem_ops} !== {32'd3, 32'd2}) begin
            tests_failed++;
            $display("FAIL counters: got stall_cnt=%0d mem_ops=%0d expected 3 2", b.stall_cnt, b.mem_ops);
        end
        b.RST = 1'b1;
        tick();
        b.RST = 1'b0;
        tests_run++;
        if ({b.stall_cnt, b.mem_ops} !== 64'd0) begin
            tests_failed++;
            $display("FAIL counters_reset: got stall_cnt=%0d mem_ops=%0d expected 0 0", b.stall_cnt, b.mem_ops);
        end
    endtask
`endif

    initial begin
        m_reset();
        test_reset();
        test_nonmem();
        test_load_latency();
        test_store_zero_wait();
        test_flush_hold();
        test_flush_in_wait();
        test_reset_mid_wait();
        test_halt_sticky();
        test_random();
`ifdef EX_MEM_STALL_CNT_EN
        test_counters();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
